// File: rtl/mfp_ahb_loader_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the serial-load write master.
package mfp_ahb_loader_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {StIdle, StAddr, StData} mst_state_e;

endpackage

// File: rtl/mfp_ahb_loader_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only alongside a pop.
module mfp_ahb_loader_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mfp_ahb_loader_master.sv
// Byte-stream to AHB-Lite write master: coalesces bytes into words, queues them and
// issues single NONSEQ writes, splitting partial words into byte transfers.
module mfp_ahb_loader_master
  import mfp_ahb_loader_master_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              big_endian,
  input  logic              in_progress,
  input  logic [31:0]       write_address,
  input  logic [7:0]        write_byte,
  input  logic              write_enable,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              loader_active,
  output logic              fifo_overflow,
  output logic              bus_error,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(BYTES);
  localparam int unsigned WA_W    = 32 - OFF_W;
  localparam int unsigned ENTRY_W = WA_W + DATA_W + BYTES;
  localparam logic [2:0]  HSIZE_FULL = (OFF_W == 3) ? HSIZE_DWORD : HSIZE_WORD;

  // Coalescer; mask bits are indexed by byte offset, data bytes sit on their bus lane.
  logic              c_valid_q, c_valid_d;
  logic [WA_W-1:0]   c_waddr_q, c_waddr_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic [BYTES-1:0]  c_mask_q, c_mask_d;
  logic              in_prog_q;

  logic [OFF_W-1:0]  in_off, in_lane;
  logic [WA_W-1:0]   in_waddr;
  logic              hit, flush;

  assign in_off   = write_address[OFF_W-1:0];
  assign in_waddr = write_address[31:OFF_W];
  assign in_lane  = big_endian ? ~in_off : in_off;
  assign hit      = c_valid_q && (c_waddr_q == in_waddr);
  assign flush    = c_valid_q &&
                    ((&c_mask_q) || (write_enable && !hit) || (in_prog_q && !in_progress));

  always_comb begin
    c_valid_d = c_valid_q;
    c_waddr_d = c_waddr_q;
    c_data_d  = c_data_q;
    c_mask_d  = c_mask_q;
    if (flush) c_valid_d = 1'b0;
    if (write_enable) begin
      if (flush || !c_valid_q) begin
        c_valid_d = 1'b1;
        c_waddr_d = in_waddr;
        c_data_d  = '0;
        c_mask_d  = '0;
      end
      c_data_d[{in_lane, 3'b000} +: 8] = write_byte;
      c_mask_d[in_off] = 1'b1;
    end
  end

  // FIFO
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_pop;

  mfp_ahb_loader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (flush),
    .wdata ({c_waddr_q, c_data_q, c_mask_q}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Master FSM and transfer register
  mst_state_e        state_q, state_d;
  logic [WA_W-1:0]   t_waddr_q, t_waddr_d;
  logic [DATA_W-1:0] t_data_q, t_data_d;
  logic [BYTES-1:0]  t_mask_q, t_mask_d;
  logic [OFF_W-1:0]  cur_off;
  logic              full_word, data_done;

  assign full_word = &t_mask_q;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign data_done = (state_q == StData) && HREADY;

  always_comb begin
    cur_off = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (t_mask_q[i]) cur_off = i[OFF_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    t_waddr_d = t_waddr_q;
    t_data_d  = t_data_q;
    t_mask_d  = t_mask_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d   = StAddr;
          t_waddr_d = fifo_rdata[ENTRY_W-1 -: WA_W];
          t_data_d  = fifo_rdata[BYTES +: DATA_W];
          t_mask_d  = fifo_rdata[BYTES-1:0];
        end
      end
      StAddr: begin
        if (HREADY) state_d = StData;
      end
      StData: begin
        if (HREADY) begin
          t_mask_d = full_word ? '0 : (t_mask_q & (t_mask_q - BYTES'(1)));
          state_d  = (|t_mask_d) ? StAddr : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic             ovf_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      c_valid_q <= 1'b0;
      c_waddr_q <= '0;
      c_data_q  <= '0;
      c_mask_q  <= '0;
      in_prog_q <= 1'b0;
      state_q   <= StIdle;
      t_waddr_q <= '0;
      t_data_q  <= '0;
      t_mask_q  <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      c_valid_q <= c_valid_d;
      c_waddr_q <= c_waddr_d;
      c_data_q  <= c_data_d;
      c_mask_q  <= c_mask_d;
      in_prog_q <= in_progress;
      state_q   <= state_d;
      t_waddr_q <= t_waddr_d;
      t_data_q  <= t_data_d;
      t_mask_q  <= t_mask_d;
      if (flush && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      if (data_done && HRESP) err_q <= 1'b1;
      if (data_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign HTRANS        = (state_q == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE        = (state_q == StAddr);
  assign HADDR         = {t_waddr_q, full_word ? {OFF_W{1'b0}} : cur_off};
  assign HSIZE         = full_word ? HSIZE_FULL : HSIZE_BYTE;
  assign HWDATA        = t_data_q;
  assign HBURST        = HBURST_SINGLE;
  assign HPROT         = HPROT_DATA;
  assign HMASTLOCK     = 1'b0;
  assign loader_active = in_progress || c_valid_q || !fifo_empty || (state_q != StIdle);
  assign fifo_overflow = ovf_q;
  assign bus_error     = err_q;
  assign xfer_count    = cnt_q;

endmodule

// File: tb/tb_mfp_ahb_loader_master.sv
// Bench for mfp_ahb_loader_master: table-driven word writes plus hand sequences, with a
// scoreboard of expected AHB transfers checked by a bus monitor.
module tb_mfp_ahb_loader_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        big_endian, in_progress, write_enable;
  logic [31:0] write_address;
  logic [7:0]  write_byte;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY, HRESP;
  logic        loader_active, fifo_overflow, bus_error;
  logic [15:0] xfer_count;

  always #5 HCLK = ~HCLK;

  mfp_ahb_loader_master #(
    .DATA_W     (32),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .big_endian    (big_endian),
    .in_progress   (in_progress),
    .write_address (write_address),
    .write_byte    (write_byte),
    .write_enable  (write_enable),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HSIZE         (HSIZE),
    .HBURST        (HBURST),
    .HPROT         (HPROT),
    .HMASTLOCK     (HMASTLOCK),
    .HWRITE        (HWRITE),
    .HWDATA        (HWDATA),
    .HREADY        (HREADY),
    .HRESP         (HRESP),
    .loader_active (loader_active),
    .fifo_overflow (fifo_overflow),
    .bus_error     (bus_error),
    .xfer_count    (xfer_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic        be;
    logic [31:0] base;
    logic [31:0] bytes;  // byte i at bits [8i+7:8i], sent to base+i
    logic [31:0] exp;
  } vec_t;

  xfer_t sb[$];
  int    nvec = 0;
  int    nerr = 0;
  int    exp_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_byte(input logic [31:0] addr, input logic [7:0] val);
    write_address = addr;
    write_byte    = val;
    write_enable  = 1'b1;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic expect_xfer(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data);
    xfer_t x;
    x.addr = addr;
    x.size = size;
    x.data = data;
    sb.push_back(x);
    exp_total++;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (loader_active && n < 300) begin
      tick();
      n++;
    end
    check({name, "_active"}, 64'(loader_active), 64'd0);
    check({name, "_sb_left"}, 64'(sb.size()), 64'd0);
    check({name, "_count"}, 64'(xfer_count), 64'(exp_total));
  endtask

  task automatic wait_nonseq(input string name);
    int n = 0;
    while (HTRANS != 2'b10 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_nonseq_seen"}, 64'(HTRANS), 64'h2);
  endtask

  // Bus monitor: compares address and data phases against the scoreboard.
  logic        in_data = 1'b0, dwait = 1'b0, awaiting = 1'b0;
  logic [31:0] last_wdata, last_addr;
  logic [2:0]  last_size;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      in_data  = 1'b0;
      dwait    = 1'b0;
      awaiting = 1'b0;
    end else if (in_data) begin
      check("htrans_in_data", 64'(HTRANS), 64'd0);
      if (dwait) check("hwdata_hold", 64'(HWDATA), 64'(last_wdata));
      if (HREADY) begin
        if (sb.size() == 0) check("unexpected_data_phase", 64'd1, 64'd0);
        else check("hwdata", 64'(HWDATA), 64'(sb.pop_front().data));
        in_data = 1'b0;
        dwait   = 1'b0;
      end else begin
        dwait      = 1'b1;
        last_wdata = HWDATA;
      end
    end else if (HTRANS == 2'b10) begin
      if (awaiting) begin
        check("haddr_hold", 64'(HADDR), 64'(last_addr));
        check("hsize_hold", 64'(HSIZE), 64'(last_size));
      end else if (sb.size() == 0) begin
        check("unexpected_nonseq", 64'd1, 64'd0);
      end else begin
        check("haddr", 64'(HADDR), 64'(sb[0].addr));
        check("hsize", 64'(HSIZE), 64'(sb[0].size));
        check("hwrite", 64'(HWRITE), 64'd1);
      end
      if (HREADY) begin
        in_data  = 1'b1;
        awaiting = 1'b0;
      end else begin
        awaiting  = 1'b1;
        last_addr = HADDR;
        last_size = HSIZE;
      end
    end
  end

  vec_t vecs[4];

  initial begin
    vecs[0] = '{be: 1'b0, base: 32'h10,   bytes: 32'h44332211, exp: 32'h44332211};
    vecs[1] = '{be: 1'b1, base: 32'h10,   bytes: 32'h44332211, exp: 32'h11223344};
    vecs[2] = '{be: 1'b0, base: 32'h44,   bytes: 32'hEFBEADDE, exp: 32'hEFBEADDE};
    vecs[3] = '{be: 1'b1, base: 32'h1000, bytes: 32'h04030201, exp: 32'h01020304};

    HRESETn = 1'b0; big_endian = 1'b0; in_progress = 1'b0; write_enable = 1'b0;
    write_address = '0; write_byte = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick();
    tick();
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_hsize", 64'(HSIZE), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    check("rst_active", 64'(loader_active), 64'd0);
    check("rst_ovf", 64'(fifo_overflow), 64'd0);
    check("rst_err", 64'(bus_error), 64'd0);
    check("rst_count", 64'(xfer_count), 64'd0);
    check("hburst", 64'(HBURST), 64'd0);
    check("hprot", 64'(HPROT), 64'h3);
    check("hmastlock", 64'(HMASTLOCK), 64'd0);
    HRESETn = 1'b1;
    tick();

    // Full-word writes in both lane orders
    for (int v = 0; v < 4; v++) begin
      big_endian  = vecs[v].be;
      in_progress = 1'b1;
      expect_xfer(vecs[v].base, 3'd2, vecs[v].exp);
      for (int i = 0; i < 4; i++) send_byte(vecs[v].base + i, vecs[v].bytes[8*i +: 8]);
      in_progress = 1'b0;
      wait_idle($sformatf("vec%0d", v));
    end

    // Partial entry flushed by in_progress falling
    big_endian  = 1'b0;
    in_progress = 1'b1;
    expect_xfer(32'h21, 3'd0, 32'h00BBAA00);
    expect_xfer(32'h22, 3'd0, 32'h00BBAA00);
    send_byte(32'h21, 8'hAA);
    send_byte(32'h22, 8'hBB);
    tick();
    in_progress = 1'b0;
    wait_idle("partial");

    // Wait states in both phases
    HREADY      = 1'b0;
    in_progress = 1'b1;
    expect_xfer(32'h30, 3'd2, 32'hD4C3B2A1);
    send_byte(32'h30, 8'hA1);
    send_byte(32'h31, 8'hB2);
    send_byte(32'h32, 8'hC3);
    send_byte(32'h33, 8'hD4);
    in_progress = 1'b0;
    wait_nonseq("wait");
    tick();
    tick();
    HREADY = 1'b1;
    tick();
    HREADY = 1'b0;
    tick();
    tick();
    HREADY = 1'b1;
    wait_idle("wait");

    // Overflow with the bus stalled, then one error response
    HREADY      = 1'b0;
    in_progress = 1'b1;
    for (int i = 0; i < 9; i++) expect_xfer(32'h100 + 8 * i, 3'd0, 32'(i + 1));
    for (int i = 0; i < 10; i++) send_byte(32'h100 + 8 * i, 8'(i + 1));
    in_progress = 1'b0;
    tick();
    tick();
    check("overflow_set", 64'(fifo_overflow), 64'd1);
    check("no_err_yet", 64'(bus_error), 64'd0);
    HREADY = 1'b1;
    HRESP  = 1'b1;
    tick();
    tick();
    HRESP = 1'b0;
    wait_idle("overflow");
    check("bus_error_set", 64'(bus_error), 64'd1);
    check("overflow_sticky", 64'(fifo_overflow), 64'd1);

    // Asynchronous reset during a data phase
    in_progress = 1'b1;
    expect_xfer(32'h200, 3'd2, 32'h78563412);
    send_byte(32'h200, 8'h12);
    send_byte(32'h201, 8'h34);
    send_byte(32'h202, 8'h56);
    send_byte(32'h203, 8'h78);
    in_progress = 1'b0;
    wait_nonseq("rstmid");
    tick();
    HREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    check("rstmid_htrans", 64'(HTRANS), 64'd0);
    check("rstmid_active", 64'(loader_active), 64'd0);
    check("rstmid_hwdata", 64'(HWDATA), 64'd0);
    check("rstmid_count", 64'(xfer_count), 64'd0);
    sb.delete();
    exp_total = 0;
    HREADY = 1'b1;
    tick();
    tick();
    HRESETn = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("post_rst_htrans", 64'(HTRANS), 64'd0);
    check("post_rst_count", 64'(xfer_count), 64'd0);
    check("post_rst_active", 64'(loader_active), 64'd0);
    check("post_rst_err", 64'(bus_error), 64'd0);
    check("post_rst_ovf", 64'(fifo_overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
